// File: rtl/fp_pkg.sv
// Shared double-precision constants and operand classification for the
// polynomial-evaluation fp datapath (multipliers and the companion adder).
package fp_pkg;
  localparam int EXP_W      = 11;
  localparam int MAN_W      = 52;
  localparam int BIAS       = 1023;
  localparam int MUL_LAT    = 10;
  localparam int FP_ADD_LAT = 4;

  localparam logic [63:0] ONE  = 64'h3FF0_0000_0000_0000;
  localparam logic [63:0] QNAN = 64'h7FF8_0000_0000_0000;

  typedef enum logic [1:0] {CLS_NORM, CLS_ZERO, CLS_INF, CLS_NAN} fp_cls_e;

  // Denormals classify as zero so they are flushed on entry.
  function automatic fp_cls_e fp_classify(input logic [63:0] x);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
    e = x[62:52];
    f = x[51:0];
    if (e == '1) return (f != '0) ? CLS_NAN : CLS_INF;
    if (e == '0) return CLS_ZERO;
    return CLS_NORM;
  endfunction

  function automatic fp_cls_e fp_mul_cls(input fp_cls_e ca, input fp_cls_e cb);
    if (ca == CLS_NAN || cb == CLS_NAN) return CLS_NAN;
    if ((ca == CLS_INF && cb == CLS_ZERO) || (ca == CLS_ZERO && cb == CLS_INF)) return CLS_NAN;
    if (ca == CLS_INF || cb == CLS_INF) return CLS_INF;
    if (ca == CLS_ZERO || cb == CLS_ZERO) return CLS_ZERO;
    return CLS_NORM;
  endfunction
endpackage

// File: rtl/fp_mul2.sv
// Five-stage double-precision multiply: unpack, split mantissa multiply (2),
// normalise, round-to-nearest-even and pack. Denormals/underflow flush to zero.
module fp_mul2
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [63:0] a,
  input  logic [63:0] b,
  output logic        out_valid,
  output logic [63:0] r
);
  localparam int MW    = MAN_W + 1;
  localparam int LO_W  = 27;
  localparam int HI_W  = MW - LO_W;
  localparam int PLO_W = MW + LO_W;
  localparam int PHI_W = MW + HI_W;
  localparam int PW    = 2 * MW;
  localparam logic signed [12:0] BIAS_S  = 13'(BIAS);
  localparam logic signed [12:0] EXP_INF = 13'sd2047;

  logic [4:0]              vld_d, vld_q;
  logic                    s1_sign_d, s1_sign_q, s2_sign_d, s2_sign_q;
  logic                    s3_sign_d, s3_sign_q, s4_sign_d, s4_sign_q;
  fp_cls_e                 s1_cls_d, s1_cls_q, s2_cls_d, s2_cls_q;
  fp_cls_e                 s3_cls_d, s3_cls_q, s4_cls_d, s4_cls_q;
  logic signed [12:0]      s1_exp_d, s1_exp_q, s2_exp_d, s2_exp_q;
  logic signed [12:0]      s3_exp_d, s3_exp_q, s4_exp_d, s4_exp_q;
  logic [MW-1:0]           s1_ma_d, s1_ma_q, s1_mb_d, s1_mb_q;
  logic [PLO_W-1:0]        s2_plo_d, s2_plo_q;
  logic [PHI_W-1:0]        s2_phi_d, s2_phi_q;
  logic [PW-1:0]           s3_prod_d, s3_prod_q;
  logic [MW-1:0]           s4_man_d, s4_man_q;
  logic                    s4_grd_d, s4_grd_q, s4_stk_d, s4_stk_q;
  logic [63:0]             r5_d, r5_q;
  logic                    rnd_up;
  logic [MW:0]             man_rnd;
  logic signed [12:0]      exp_rnd;
  logic [MAN_W-1:0]        frac;

  always_comb begin
    vld_d     = {vld_q[3:0], in_valid};

    s1_sign_d = a[63] ^ b[63];
    s1_cls_d  = fp_mul_cls(fp_classify(a), fp_classify(b));
    s1_exp_d  = $signed({2'b00, a[62:52]}) + $signed({2'b00, b[62:52]}) - BIAS_S;
    s1_ma_d   = {1'b1, a[MAN_W-1:0]};
    s1_mb_d   = {1'b1, b[MAN_W-1:0]};

    // 53x53 product split into two narrower partial products.
    s2_sign_d = s1_sign_q;
    s2_cls_d  = s1_cls_q;
    s2_exp_d  = s1_exp_q;
    s2_plo_d  = PLO_W'(s1_ma_q) * PLO_W'(s1_mb_q[LO_W-1:0]);
    s2_phi_d  = PHI_W'(s1_ma_q) * PHI_W'(s1_mb_q[MW-1:LO_W]);

    s3_sign_d = s2_sign_q;
    s3_cls_d  = s2_cls_q;
    s3_exp_d  = s2_exp_q;
    s3_prod_d = PW'(s2_plo_q) + {s2_phi_q, {LO_W{1'b0}}};

    s4_sign_d = s3_sign_q;
    s4_cls_d  = s3_cls_q;
    if (s3_prod_q[PW-1]) begin
      s4_man_d = s3_prod_q[PW-1:MW];
      s4_grd_d = s3_prod_q[MW-1];
      s4_stk_d = |s3_prod_q[MW-2:0];
      s4_exp_d = s3_exp_q + 13'sd1;
    end else begin
      s4_man_d = s3_prod_q[PW-2:MW-1];
      s4_grd_d = s3_prod_q[MW-2];
      s4_stk_d = |s3_prod_q[MW-3:0];
      s4_exp_d = s3_exp_q;
    end

    rnd_up  = s4_grd_q & (s4_stk_q | s4_man_q[0]);
    man_rnd = {1'b0, s4_man_q} + (MW+1)'(rnd_up);
    exp_rnd = man_rnd[MW] ? s4_exp_q + 13'sd1 : s4_exp_q;
    frac    = man_rnd[MW] ? man_rnd[MW-1:1] : man_rnd[MW-2:0];

    case (s4_cls_q)
      CLS_NAN:  r5_d = QNAN;
      CLS_INF:  r5_d = {s4_sign_q, 11'h7FF, 52'h0};
      CLS_ZERO: r5_d = {s4_sign_q, 63'h0};
      default: begin
        if (exp_rnd >= EXP_INF)    r5_d = {s4_sign_q, 11'h7FF, 52'h0};
        else if (exp_rnd <= 13'sd0) r5_d = {s4_sign_q, 63'h0};
        else                        r5_d = {s4_sign_q, exp_rnd[10:0], frac};
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q     <= '0;
      s1_sign_q <= 1'b0;  s2_sign_q <= 1'b0;  s3_sign_q <= 1'b0;  s4_sign_q <= 1'b0;
      s1_cls_q  <= CLS_NORM;  s2_cls_q <= CLS_NORM;
      s3_cls_q  <= CLS_NORM;  s4_cls_q <= CLS_NORM;
      s1_exp_q  <= '0;  s2_exp_q <= '0;  s3_exp_q <= '0;  s4_exp_q <= '0;
      s1_ma_q   <= '0;  s1_mb_q  <= '0;
      s2_plo_q  <= '0;  s2_phi_q <= '0;
      s3_prod_q <= '0;
      s4_man_q  <= '0;  s4_grd_q <= 1'b0;  s4_stk_q <= 1'b0;
      r5_q      <= '0;
    end else begin
      vld_q     <= vld_d;
      s1_sign_q <= s1_sign_d;  s2_sign_q <= s2_sign_d;
      s3_sign_q <= s3_sign_d;  s4_sign_q <= s4_sign_d;
      s1_cls_q  <= s1_cls_d;   s2_cls_q  <= s2_cls_d;
      s3_cls_q  <= s3_cls_d;   s4_cls_q  <= s4_cls_d;
      s1_exp_q  <= s1_exp_d;   s2_exp_q  <= s2_exp_d;
      s3_exp_q  <= s3_exp_d;   s4_exp_q  <= s4_exp_d;
      s1_ma_q   <= s1_ma_d;    s1_mb_q   <= s1_mb_d;
      s2_plo_q  <= s2_plo_d;   s2_phi_q  <= s2_phi_d;
      s3_prod_q <= s3_prod_d;
      s4_man_q  <= s4_man_d;   s4_grd_q  <= s4_grd_d;  s4_stk_q <= s4_stk_d;
      r5_q      <= r5_d;
    end
  end

  assign out_valid = vld_q[4];
  assign r         = r5_q;
endmodule

// File: rtl/fp_mul3.sv
// Three-operand double multiply r = (a*b)*c with a fixed 10-cycle latency,
// built from two five-stage multipliers in series.
module fp_mul3
  import fp_pkg::*;
#(
  parameter int LATENCY = MUL_LAT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pushin,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic [63:0] c,
  output logic        pushout,
  output logic [63:0] r
);
  localparam int C_DLY = LATENCY / 2;

  logic [63:0] c_pipe_d [C_DLY];
  logic [63:0] c_pipe_q [C_DLY];
  logic        t_vld;
  logic [63:0] t;
  logic        r_vld;
  logic [63:0] r_raw;

  // c waits out the first multiplier so it meets its own a*b product.
  always_comb begin
    c_pipe_d[0] = c;
    for (int i = 1; i < C_DLY; i++) c_pipe_d[i] = c_pipe_q[i-1];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < C_DLY; i++) c_pipe_q[i] <= '0;
    end else begin
      c_pipe_q <= c_pipe_d;
    end
  end

  fp_mul2 u_mul_ab (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (pushin),
    .a         (a),
    .b         (b),
    .out_valid (t_vld),
    .r         (t)
  );

  fp_mul2 u_mul_tc (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (t_vld),
    .a         (t),
    .b         (c_pipe_q[C_DLY-1]),
    .out_valid (r_vld),
    .r         (r_raw)
  );

  assign pushout = r_vld;
  assign r       = r_vld ? r_raw : '0;
endmodule

// File: tb/tb_fp_mul3.sv
// Scoreboard bench for fp_mul3: the driver queues expected results with their
// due cycle, a monitor pops and compares whenever pushout is (or should be) high.
module tb_fp_mul3;
  localparam int LAT = 10;
  localparam logic [63:0] QNAN_C = 64'h7FF8_0000_0000_0000;

  typedef struct {
    logic [63:0] r;
    int          due;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pushin = 1'b0;
  logic [63:0] a = '0, b = '0, c = '0;
  logic        pushout;
  logic [63:0] r;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   seen_out = 1'b0;
  exp_t sb_q[$];

  fp_mul3 dut (
    .clk     (clk),
    .rst     (rst),
    .pushin  (pushin),
    .a       (a),
    .b       (b),
    .c       (c),
    .pushout (pushout),
    .r       (r)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp_v);
    end
  endtask

  // Reference: real-number multiply with flush-to-zero and IEEE special rules.
  function automatic logic [63:0] ref_mul(input logic [63:0] x, input logic [63:0] y);
    logic        s;
    logic [63:0] p;
    bit xn, yn, xi, yi, xz, yz;
    s  = x[63] ^ y[63];
    xn = (x[62:52] == 11'h7FF) && (x[51:0] != 0);
    yn = (y[62:52] == 11'h7FF) && (y[51:0] != 0);
    xi = (x[62:52] == 11'h7FF) && (x[51:0] == 0);
    yi = (y[62:52] == 11'h7FF) && (y[51:0] == 0);
    xz = (x[62:52] == 11'h000);
    yz = (y[62:52] == 11'h000);
    if (xn || yn || (xi && yz) || (xz && yi)) return QNAN_C;
    if (xi || yi) return {s, 11'h7FF, 52'h0};
    if (xz || yz) return {s, 63'h0};
    p = $realtobits($bitstoreal(x) * $bitstoreal(y));
    if (p[62:52] == 11'h000) return {s, 63'h0};
    return p;
  endfunction

  function automatic logic [63:0] ref_mul3(input logic [63:0] x, input logic [63:0] y,
                                           input logic [63:0] z);
    return ref_mul(ref_mul(x, y), z);
  endfunction

  function automatic logic [63:0] rnd_norm(input int spread);
    logic [63:0] m;
    logic [10:0] e;
    m = {$urandom, $urandom};
    e = 11'(1023 - spread + int'($urandom_range(2 * spread)));
    return {1'($urandom_range(1)), e, m[51:0]};
  endfunction

  task automatic issue(input logic [63:0] xa, input logic [63:0] xb, input logic [63:0] xc,
                       input logic [63:0] exp_r);
    exp_t e;
    @(posedge clk); #1;
    pushin = 1'b1;
    a = xa; b = xb; c = xc;
    e.r   = exp_r;
    e.due = cyc + LAT;
    sb_q.push_back(e);
  endtask

  task automatic issue_model(input logic [63:0] xa, input logic [63:0] xb, input logic [63:0] xc);
    issue(xa, xb, xc, ref_mul3(xa, xb, xc));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      pushin = 1'b0;
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; c = {$urandom, $urandom};
    end
  endtask

  // Monitor: every output cycle is either a due result or must be idle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        seen_out = 1'b0;
      end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        e = sb_q.pop_front();
        chk("pushout_at_due", 64'(pushout), 64'd1);
        if (pushout) chk("r_value", r, e.r);
      end else begin
        chk("no_unexpected_pushout", 64'(pushout), 64'd0);
        if (!seen_out) chk("r_zero_before_data", r, 64'h0);
      end
      if (rst && pushout) seen_out = 1'b1;
    end
  end

  initial begin
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_pushout", 64'(pushout), 64'd0);
    chk("reset_r", r, 64'h0);
    rst = 1'b1;
    idle(2);

    issue(64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000,
          64'h3FF0_0000_0000_0000);
    idle(3);
    issue(64'h4000_0000_0000_0000, 64'h4008_0000_0000_0000, 64'h3FE0_0000_0000_0000,
          64'h4008_0000_0000_0000);
    issue(64'hBFF8_0000_0000_0000, 64'h4008_0000_0000_0000, 64'h3FE0_0000_0000_0000,
          64'hC002_0000_0000_0000);
    issue(64'h0000_0000_0000_0000, 64'h7FF0_0000_0000_0000, 64'h3FF0_0000_0000_0000,
          64'h7FF8_0000_0000_0000);
    issue(64'h7FEF_FFFF_FFFF_FFFF, 64'h4000_0000_0000_0000, 64'h3FF0_0000_0000_0000,
          64'h7FF0_0000_0000_0000);
    issue(64'h8000_0000_0000_0000, 64'h4008_0000_0000_0000, 64'h3FF0_0000_0000_0000,
          64'h8000_0000_0000_0000);
    // Further specials: NaN operand, signed inf, inf*0 at step two, denormal, underflow.
    issue_model(64'h7FF0_0000_0000_0001, rnd_norm(10), rnd_norm(10));
    issue_model(64'hFFF0_0000_0000_0000, 64'hC000_0000_0000_0000, 64'h4008_0000_0000_0000);
    issue_model(64'h7FF0_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h0000_0000_0000_0000);
    issue_model(64'h8000_0000_0000_0001, rnd_norm(10), rnd_norm(10));
    issue_model({1'b0, 11'(1023 - 600), 52'h12345}, {1'b1, 11'(1023 - 600), 52'h6789A},
                64'h3FF0_0000_0000_0000);
    idle(2);

    for (int i = 0; i < 20; i++) issue_model(rnd_norm(150), rnd_norm(150), rnd_norm(150));
    idle(3);
    for (int i = 0; i < 5; i++) issue_model(rnd_norm(150), rnd_norm(150), rnd_norm(150));
    idle(LAT + 2);

    // Reset with six results in flight: all of them must vanish.
    for (int i = 0; i < 6; i++) issue_model(rnd_norm(100), rnd_norm(100), rnd_norm(100));
    @(posedge clk); #1;
    pushin = 1'b0;
    rst = 1'b0;
    #1;
    chk("midreset_pushout", 64'(pushout), 64'd0);
    chk("midreset_r", r, 64'h0);
    sb_q.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    idle(12);

    idle(15);

    for (int i = 0; i < 5; i++) issue_model(rnd_norm(200), rnd_norm(200), ref_mul(64'h3FF0_0000_0000_0000, rnd_norm(200)));
    issue_model(rnd_norm(50), rnd_norm(50), 64'h3FF0_0000_0000_0000);
    idle(1);

    for (int i = 0; i < 4 * LAT && sb_q.size() > 0; i++) @(posedge clk);
    if (sb_q.size() > 0) chk("drain_timeout", 64'(sb_q.size()), 64'd0);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
